// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared states, opcodes, ALU codes, mux selects and exception causes
package control_unit_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_R_EXEC     = 5'd4,
        S_R_WB       = 5'd5,
        S_ADDI_EXEC  = 5'd6,
        S_ADDI_WB    = 5'd7,
        S_MEM_ADDR   = 5'd8,
        S_LW_REQ     = 5'd9,
        S_LW_WAIT    = 5'd10,
        S_LW_WB      = 5'd11,
        S_SW_WRITE   = 5'd12,
        S_BEQ_EXEC   = 5'd13,
        S_J_EXEC     = 5'd14,
        S_MULT_START = 5'd15,
        S_MULT_WAIT  = 5'd16,
        S_MULT_DONE  = 5'd17,
        S_EXC        = 5'd18
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_MULT = 6'h18;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_EXC    = 2'd3;

    localparam logic [1:0] MEM_SRC_PC     = 2'd0;
    localparam logic [1:0] MEM_SRC_ALUOUT = 2'd1;

    localparam logic [1:0] WREG_RT = 2'd0;
    localparam logic [1:0] WREG_RD = 2'd1;

    localparam logic [1:0] WDATA_ALUOUT = 2'd0;
    localparam logic [1:0] WDATA_MDR    = 2'd1;

    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_A  = 2'd1;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] EXC_NONE         = 2'd0;
    localparam logic [1:0] EXC_OPCODE       = 2'd1;
    localparam logic [1:0] EXC_OVERFLOW     = 2'd2;
    localparam logic [1:0] EXC_MULT_TIMEOUT = 2'd3;

    function automatic logic [3:0] alu_op_for_funct(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_watchdog.sv
// rtl/control_unit_watchdog.sv - mult wait-cycle counter with timeout flag
module mult_watchdog #(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int CW = $clog2(MULT_TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(MULT_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Count holds the number of completed wait cycles, so the flag fires on the last allowed one.
    assign timeout = enable && (count == LIMIT);
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle CPU control FSM with Moore-decoded datapath controls
import control_unit_pkg::*;

module control_unit #(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    input  logic       OVERFLOW,
    input  logic       mult_end,
    output logic       PC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       AB_w,
    output logic       ALUOut_w,
    output logic       RB_w,
    output logic       MEM_DATA_REG_w,
    output logic       EPC_w,
    output logic       HILO_w,
    output logic       mult_control,
    output logic [1:0] M_PC,
    output logic [1:0] M_MEM,
    output logic [1:0] M_WREG,
    output logic [1:0] M_WDATA,
    output logic [1:0] M_ALUSrcA,
    output logic [1:0] M_ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] exc_cause,
    output logic [4:0] state_dbg
);
    state_t     state, next_state;
    logic       exc_load;
    logic [1:0] exc_next;
    logic       mult_timeout;

    mult_watchdog #(.MULT_TIMEOUT(MULT_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (state == S_MULT_START),
        .enable  (state == S_MULT_WAIT),
        .timeout (mult_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RESET;
            exc_cause <= EXC_NONE;
        end else begin
            state <= next_state;
            if (exc_load) begin
                exc_cause <= exc_next;
            end
        end
    end

    assign state_dbg = state;

    always_comb begin
        next_state     = state;
        exc_load       = 1'b0;
        exc_next       = EXC_NONE;
        PC_w           = 1'b0;
        MEM_w          = 1'b0;
        IR_w           = 1'b0;
        AB_w           = 1'b0;
        ALUOut_w       = 1'b0;
        RB_w           = 1'b0;
        MEM_DATA_REG_w = 1'b0;
        EPC_w          = 1'b0;
        HILO_w         = 1'b0;
        mult_control   = 1'b0;
        M_PC           = PC_SRC_ALU;
        M_MEM          = MEM_SRC_PC;
        M_WREG         = WREG_RT;
        M_WDATA        = WDATA_ALUOUT;
        M_ALUSrcA      = SRCA_PC;
        M_ALUSrcB      = SRCB_B;
        ALUOp          = ALU_PASS;

        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                M_MEM      = MEM_SRC_PC;
                M_ALUSrcA  = SRCA_PC;
                M_ALUSrcB  = SRCB_FOUR;
                ALUOp      = ALU_ADD;
                PC_w       = 1'b1;
                M_PC       = PC_SRC_ALU;
                next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                IR_w       = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BEQ_EXEC can select it from ALUOut.
                AB_w      = 1'b1;
                M_ALUSrcA = SRCA_PC;
                M_ALUSrcB = SRCB_IMM_SH2;
                ALUOp     = ALU_ADD;
                ALUOut_w  = 1'b1;
                case (OPCODE)
                    OP_RTYPE: begin
                        if (FUNCT == FN_ADD || FUNCT == FN_SUB || FUNCT == FN_AND) begin
                            next_state = S_R_EXEC;
                        end else if (FUNCT == FN_MULT) begin
                            next_state = S_MULT_START;
                        end else begin
                            next_state = S_EXC;
                            exc_load   = 1'b1;
                            exc_next   = EXC_OPCODE;
                        end
                    end
                    OP_ADDI:      next_state = S_ADDI_EXEC;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_BEQ:       next_state = S_BEQ_EXEC;
                    OP_J:         next_state = S_J_EXEC;
                    default: begin
                        next_state = S_EXC;
                        exc_load   = 1'b1;
                        exc_next   = EXC_OPCODE;
                    end
                endcase
            end
            S_R_EXEC: begin
                M_ALUSrcA = SRCA_A;
                M_ALUSrcB = SRCB_B;
                ALUOp     = alu_op_for_funct(FUNCT);
                ALUOut_w  = 1'b1;
                if (OVERFLOW && FUNCT != FN_AND) begin
                    next_state = S_EXC;
                    exc_load   = 1'b1;
                    exc_next   = EXC_OVERFLOW;
                end else begin
                    next_state = S_R_WB;
                end
            end
            S_R_WB: begin
                RB_w       = 1'b1;
                M_WREG     = WREG_RD;
                M_WDATA    = WDATA_ALUOUT;
                next_state = S_FETCH;
            end
            S_ADDI_EXEC: begin
                M_ALUSrcA = SRCA_A;
                M_ALUSrcB = SRCB_IMM;
                ALUOp     = ALU_ADD;
                ALUOut_w  = 1'b1;
                if (OVERFLOW) begin
                    next_state = S_EXC;
                    exc_load   = 1'b1;
                    exc_next   = EXC_OVERFLOW;
                end else begin
                    next_state = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                RB_w       = 1'b1;
                M_WREG     = WREG_RT;
                M_WDATA    = WDATA_ALUOUT;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                M_ALUSrcA  = SRCA_A;
                M_ALUSrcB  = SRCB_IMM;
                ALUOp      = ALU_ADD;
                ALUOut_w   = 1'b1;
                next_state = (OPCODE == OP_SW) ? S_SW_WRITE : S_LW_REQ;
            end
            S_LW_REQ: begin
                M_MEM      = MEM_SRC_ALUOUT;
                next_state = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                MEM_DATA_REG_w = 1'b1;
                next_state     = S_LW_WB;
            end
            S_LW_WB: begin
                RB_w       = 1'b1;
                M_WREG     = WREG_RT;
                M_WDATA    = WDATA_MDR;
                next_state = S_FETCH;
            end
            S_SW_WRITE: begin
                M_MEM      = MEM_SRC_ALUOUT;
                MEM_w      = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ_EXEC: begin
                M_ALUSrcA  = SRCA_A;
                M_ALUSrcB  = SRCB_B;
                ALUOp      = ALU_SUB;
                PC_w       = ZERO;
                M_PC       = PC_SRC_ALUOUT;
                next_state = S_FETCH;
            end
            S_J_EXEC: begin
                PC_w       = 1'b1;
                M_PC       = PC_SRC_JUMP;
                next_state = S_FETCH;
            end
            S_MULT_START: begin
                mult_control = 1'b1;
                next_state   = S_MULT_WAIT;
            end
            S_MULT_WAIT: begin
                if (mult_end) begin
                    next_state = S_MULT_DONE;
                end else if (mult_timeout) begin
                    next_state = S_EXC;
                    exc_load   = 1'b1;
                    exc_next   = EXC_MULT_TIMEOUT;
                end
            end
            S_MULT_DONE: begin
                HILO_w     = 1'b1;
                next_state = S_FETCH;
            end
            S_EXC: begin
                // PC already advanced by 4 in FETCH, so EPC gets PC-4.
                M_ALUSrcA  = SRCA_PC;
                M_ALUSrcB  = SRCB_FOUR;
                ALUOp      = ALU_SUB;
                EPC_w      = 1'b1;
                PC_w       = 1'b1;
                M_PC       = PC_SRC_EXC;
                next_state = S_FETCH;
            end
            default: next_state = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OPCODE = 6'h00;
    logic [5:0] FUNCT = 6'h20;
    logic       ZERO = 1'b0;
    logic       OVERFLOW = 1'b0;
    logic       mult_end = 1'b0;
    logic       PC_w, MEM_w, IR_w, AB_w, ALUOut_w, RB_w, MEM_DATA_REG_w, EPC_w, HILO_w, mult_control;
    logic [1:0] M_PC, M_MEM, M_WREG, M_WDATA, M_ALUSrcA, M_ALUSrcB, exc_cause;
    logic [3:0] ALUOp;
    logic [4:0] state_dbg;
    logic [32:0] all_outs;

    int errors = 0;
    int checks = 0;

    control_unit #(.MULT_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .OVERFLOW(OVERFLOW), .mult_end(mult_end), .PC_w(PC_w), .MEM_w(MEM_w),
        .IR_w(IR_w), .AB_w(AB_w), .ALUOut_w(ALUOut_w), .RB_w(RB_w),
        .MEM_DATA_REG_w(MEM_DATA_REG_w), .EPC_w(EPC_w), .HILO_w(HILO_w),
        .mult_control(mult_control), .M_PC(M_PC), .M_MEM(M_MEM), .M_WREG(M_WREG),
        .M_WDATA(M_WDATA), .M_ALUSrcA(M_ALUSrcA), .M_ALUSrcB(M_ALUSrcB),
        .ALUOp(ALUOp), .exc_cause(exc_cause), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign all_outs = {PC_w, MEM_w, IR_w, AB_w, ALUOut_w, RB_w, MEM_DATA_REG_w, EPC_w, HILO_w,
                       mult_control, M_PC, M_MEM, M_WREG, M_WDATA, M_ALUSrcA, M_ALUSrcB,
                       ALUOp, exc_cause, state_dbg};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (all_outs !== 33'd0) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got %h expected 0", i, all_outs);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({state_dbg, PC_w, M_ALUSrcB, ALUOp} !== {5'd1, 1'b1, 2'd1, 4'd1}) begin
            errors++;
            $display("FAIL reset_fetch: got st=%0d pcw=%b srcb=%0d aluop=%0d expected st=1 pcw=1 srcb=1 aluop=1",
                     state_dbg, PC_w, M_ALUSrcB, ALUOp);
        end
    endtask

    task automatic test_add();
        OPCODE = 6'h00; FUNCT = 6'h20; OVERFLOW = 1'b0;
        tick();
        checks++;
        if ({state_dbg, IR_w} !== {5'd2, 1'b1}) begin
            errors++; $display("FAIL add_fetch_wait: got st=%0d irw=%b expected st=2 irw=1", state_dbg, IR_w);
        end
        tick();
        checks++;
        if ({state_dbg, AB_w, ALUOut_w, M_ALUSrcB, ALUOp} !== {5'd3, 1'b1, 1'b1, 2'd3, 4'd1}) begin
            errors++; $display("FAIL add_decode: got st=%0d abw=%b aluoutw=%b srcb=%0d aluop=%0d expected 3 1 1 3 1",
                               state_dbg, AB_w, ALUOut_w, M_ALUSrcB, ALUOp);
        end
        tick();
        checks++;
        if ({state_dbg, M_ALUSrcA, M_ALUSrcB, ALUOp, ALUOut_w} !== {5'd4, 2'd1, 2'd0, 4'd1, 1'b1}) begin
            errors++; $display("FAIL add_exec: got st=%0d srca=%0d srcb=%0d aluop=%0d expected 4 1 0 1", state_dbg, M_ALUSrcA, M_ALUSrcB, ALUOp);
        end
        tick();
        checks++;
        if ({state_dbg, RB_w, M_WREG, M_WDATA} !== {5'd5, 1'b1, 2'd1, 2'd0}) begin
            errors++; $display("FAIL add_wb: got st=%0d rbw=%b wreg=%0d wdata=%0d expected 5 1 1 0", state_dbg, RB_w, M_WREG, M_WDATA);
        end
        tick();
        checks++;
        if (state_dbg !== 5'd1) begin
            errors++; $display("FAIL add_return: got st=%0d expected 1", state_dbg);
        end
    endtask

    task automatic test_sub_and();
        FUNCT = 6'h22; OVERFLOW = 1'b0;
        repeat (3) tick();
        checks++;
        if ({state_dbg, ALUOp} !== {5'd4, 4'd2}) begin
            errors++; $display("FAIL sub_exec: got st=%0d aluop=%0d expected 4 2", state_dbg, ALUOp);
        end
        repeat (2) tick();
        FUNCT = 6'h24; OVERFLOW = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state_dbg, ALUOp} !== {5'd4, 4'd3}) begin
            errors++; $display("FAIL and_exec: got st=%0d aluop=%0d expected 4 3", state_dbg, ALUOp);
        end
        tick();
        checks++;
        if ({state_dbg, RB_w, exc_cause} !== {5'd5, 1'b1, 2'd0}) begin
            errors++; $display("FAIL and_ovf_ignored: got st=%0d rbw=%b cause=%0d expected 5 1 0", state_dbg, RB_w, exc_cause);
        end
        tick();
        OVERFLOW = 1'b0;
    endtask

    task automatic test_lw_sw();
        OPCODE = 6'h23; OVERFLOW = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state_dbg, M_ALUSrcB, ALUOut_w} !== {5'd8, 2'd2, 1'b1}) begin
            errors++; $display("FAIL lw_addr: got st=%0d srcb=%0d expected 8 2", state_dbg, M_ALUSrcB);
        end
        tick();
        checks++;
        if ({state_dbg, M_MEM} !== {5'd9, 2'd1}) begin
            errors++; $display("FAIL lw_req: got st=%0d mmem=%0d expected 9 1", state_dbg, M_MEM);
        end
        tick();
        checks++;
        if ({state_dbg, MEM_DATA_REG_w, RB_w} !== {5'd10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL lw_wait: got st=%0d mdrw=%b rbw=%b expected 10 1 0", state_dbg, MEM_DATA_REG_w, RB_w);
        end
        tick();
        checks++;
        if ({state_dbg, RB_w, M_WREG, M_WDATA} !== {5'd11, 1'b1, 2'd0, 2'd1}) begin
            errors++; $display("FAIL lw_wb: got st=%0d rbw=%b wreg=%0d wdata=%0d expected 11 1 0 1", state_dbg, RB_w, M_WREG, M_WDATA);
        end
        tick();
        OPCODE = 6'h2B; OVERFLOW = 1'b0;
        repeat (4) tick();
        checks++;
        if ({state_dbg, MEM_w, M_MEM} !== {5'd12, 1'b1, 2'd1}) begin
            errors++; $display("FAIL sw_write: got st=%0d memw=%b mmem=%0d expected 12 1 1", state_dbg, MEM_w, M_MEM);
        end
        tick();
        checks++;
        if ({state_dbg, MEM_w} !== {5'd1, 1'b0}) begin
            errors++; $display("FAIL sw_return: got st=%0d memw=%b expected 1 0", state_dbg, MEM_w);
        end
    endtask

    task automatic test_branch_jump();
        OPCODE = 6'h04; ZERO = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state_dbg, PC_w, M_PC, ALUOp} !== {5'd13, 1'b1, 2'd1, 4'd2}) begin
            errors++; $display("FAIL beq_taken: got st=%0d pcw=%b mpc=%0d aluop=%0d expected 13 1 1 2", state_dbg, PC_w, M_PC, ALUOp);
        end
        tick();
        ZERO = 1'b0;
        repeat (3) tick();
        checks++;
        if ({state_dbg, PC_w} !== {5'd13, 1'b0}) begin
            errors++; $display("FAIL beq_not_taken: got st=%0d pcw=%b expected 13 0", state_dbg, PC_w);
        end
        tick();
        OPCODE = 6'h02;
        repeat (3) tick();
        checks++;
        if ({state_dbg, PC_w, M_PC} !== {5'd14, 1'b1, 2'd2}) begin
            errors++; $display("FAIL j_exec: got st=%0d pcw=%b mpc=%0d expected 14 1 2", state_dbg, PC_w, M_PC);
        end
        tick();
    endtask

    task automatic test_addi_exceptions();
        OPCODE = 6'h08; OVERFLOW = 1'b0;
        repeat (4) tick();
        checks++;
        if ({state_dbg, RB_w, M_WREG, M_WDATA} !== {5'd7, 1'b1, 2'd0, 2'd0}) begin
            errors++; $display("FAIL addi_wb: got st=%0d rbw=%b wreg=%0d expected 7 1 0", state_dbg, RB_w, M_WREG);
        end
        tick();
        OVERFLOW = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state_dbg, M_ALUSrcB} !== {5'd6, 2'd2}) begin
            errors++; $display("FAIL addi_exec: got st=%0d srcb=%0d expected 6 2", state_dbg, M_ALUSrcB);
        end
        tick();
        checks++;
        if ({state_dbg, EPC_w, PC_w, M_PC, ALUOp, M_ALUSrcB, exc_cause, RB_w, MEM_w, HILO_w}
            !== {5'd18, 1'b1, 1'b1, 2'd3, 4'd2, 2'd1, 2'd2, 3'b000}) begin
            errors++; $display("FAIL addi_ovf_exc: got st=%0d epcw=%b pcw=%b mpc=%0d aluop=%0d cause=%0d rb/mem/hilo=%b%b%b expected 18 1 1 3 2 2 000",
                               state_dbg, EPC_w, PC_w, M_PC, ALUOp, exc_cause, RB_w, MEM_w, HILO_w);
        end
        tick();
        checks++;
        if ({state_dbg, exc_cause} !== {5'd1, 2'd2}) begin
            errors++; $display("FAIL exc_cause_hold: got st=%0d cause=%0d expected 1 2", state_dbg, exc_cause);
        end
        OVERFLOW = 1'b0; OPCODE = 6'h3F;
        repeat (3) tick();
        checks++;
        if ({state_dbg, exc_cause, EPC_w} !== {5'd18, 2'd1, 1'b1}) begin
            errors++; $display("FAIL invalid_opcode: got st=%0d cause=%0d epcw=%b expected 18 1 1", state_dbg, exc_cause, EPC_w);
        end
        tick();
    endtask

    task automatic test_mult();
        OPCODE = 6'h00; FUNCT = 6'h18;
        repeat (3) tick();
        checks++;
        if ({state_dbg, mult_control} !== {5'd15, 1'b1}) begin
            errors++; $display("FAIL mult_start: got st=%0d mc=%b expected 15 1", state_dbg, mult_control);
        end
        mult_end = 1'b1;
        tick();
        mult_end = 1'b0;
        repeat (4) tick();
        checks++;
        if ({state_dbg, mult_control} !== {5'd16, 1'b0}) begin
            errors++; $display("FAIL mult_wait: got st=%0d mc=%b expected 16 0", state_dbg, mult_control);
        end
        mult_end = 1'b1;
        tick();
        mult_end = 1'b0;
        checks++;
        if ({state_dbg, HILO_w} !== {5'd17, 1'b1}) begin
            errors++; $display("FAIL mult_done: got st=%0d hilow=%b expected 17 1", state_dbg, HILO_w);
        end
        tick();
        checks++;
        if ({state_dbg, HILO_w} !== {5'd1, 1'b0}) begin
            errors++; $display("FAIL mult_return: got st=%0d hilow=%b expected 1 0", state_dbg, HILO_w);
        end
    endtask

    task automatic test_mult_timeout();
        int cnt = 0;
        repeat (4) tick();
        while (state_dbg == 5'd16 && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 8) begin
            errors++; $display("FAIL mult_timeout_cycles: got %0d expected 8", cnt);
        end
        checks++;
        if ({state_dbg, exc_cause, HILO_w, RB_w} !== {5'd18, 2'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mult_timeout_exc: got st=%0d cause=%0d hilow=%b expected 18 3 0", state_dbg, exc_cause, HILO_w);
        end
        tick();
        repeat (4) tick();
        repeat (7) tick();
        mult_end = 1'b1;
        tick();
        mult_end = 1'b0;
        checks++;
        if ({state_dbg, HILO_w, exc_cause} !== {5'd17, 1'b1, 2'd3}) begin
            errors++; $display("FAIL mult_end_beats_timeout: got st=%0d hilow=%b cause=%0d expected 17 1 3", state_dbg, HILO_w, exc_cause);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        repeat (4) tick();
        repeat (2) tick();
        #1 reset = 1'b0;
        #1;
        checks++;
        if (all_outs !== 33'd0) begin
            errors++; $display("FAIL reset_mid_mult: got %h expected 0", all_outs);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({state_dbg, exc_cause} !== {5'd1, 2'd0}) begin
            errors++; $display("FAIL reset_mid_refetch: got st=%0d cause=%0d expected 1 0", state_dbg, exc_cause);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and();
        test_lw_sw();
        test_branch_jump();
        test_addi_exceptions();
        test_mult();
        test_mult_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name:
control_unit

Overview:
Multicycle control FSM ("UC") that sequences the CPU datapath (PC, Memoria, IR, register bank, A/B, ALU, ALUOut, MDR, mult). It covers add/sub/and/mult (R-type), addi, lw, sw, beq, j, and overflow/invalid-opcode/mult-timeout exceptions. Control outputs are Moore, decoded from state; the only exception is beq's PC_w, which is gated by ZERO.

Parameters:
MULT_TIMEOUT, 64, max cycles in MULT_WAIT before a timeout exception is raised.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset)
OPCODE  in  6  IR[31:26]
FUNCT  in  6  IR[5:0]
ZERO  in  1  ALU zero flag (combinational, same cycle)
OVERFLOW  in  1  ALU signed-overflow flag (same cycle)
mult_end  in  1  mult result ready, 1-cycle pulse
PC_w  out  1  PC load enable
MEM_w  out  1  memory write enable
IR_w  out  1  IR load enable
AB_w  out  1  A/B register load enable
ALUOut_w  out  1  ALUOut register load enable
RB_w  out  1  register bank write enable
MEM_DATA_REG_w  out  1  MDR load enable
EPC_w  out  1  EPC load enable (ALU result)
HILO_w  out  1  hi/lo load enable
mult_control  out  1  mult start, 1-cycle pulse
M_PC  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 exception vector
M_MEM  out  2  0 PC, 1 ALUOut
M_WREG  out  2  0 rt, 1 rd
M_WDATA  out  2  0 ALUOut, 1 MDR
M_ALUSrcA  out  2  0 PC, 1 A
M_ALUSrcB  out  2  0 B, 1 const 4, 2 sext(imm), 3 sext(imm)<<2
ALUOp  out  4  0 PASS, 1 ADD, 2 SUB, 3 AND
exc_cause  out  2  registered: 0 none, 1 invalid opcode, 2 overflow, 3 mult timeout
state_dbg  out  5  current state encoding

Behaviour:
- Reset (reset=0, async): state=RESET, counter=0, exc_cause=0. All outputs are 0 in RESET. The first edge after release goes RESET→FETCH. A reset mid-instruction (including in MULT_WAIT) aborts immediately, and no enable is asserted.
- Memory is synchronous: the address is sampled at an edge and the data is valid in the following cycle.
- FETCH: M_MEM=0, SrcA=0, SrcB=1, ADD, PC_w=1 (M_PC=0) → FETCH_WAIT.
- FETCH_WAIT: IR_w=1 → DECODE.
- DECODE: AB_w=1, SrcA=0, SrcB=3, ADD, ALUOut_w=1 (branch target). Dispatch:
  - op 0x00 with funct 0x20/0x22/0x24 → R_EXEC; funct 0x18 → MULT_START
  - 0x08 → ADDI_EXEC
  - 0x23/0x2B → MEM_ADDR
  - 0x04 → BEQ_EXEC
  - 0x02 → J_EXEC
  - anything else → EXC, cause 1
- R_EXEC: SrcA=1, SrcB=0, ALUOp from funct, ALUOut_w=1. If OVERFLOW and funct≠0x24 → EXC, cause 2; else → R_WB.
- R_WB: RB_w=1, M_WREG=1, M_WDATA=0 → FETCH.
- ADDI_EXEC: SrcA=1, SrcB=2, ADD, ALUOut_w=1. OVERFLOW → EXC, cause 2; else → ADDI_WB.
- ADDI_WB: RB_w=1, M_WREG=0, M_WDATA=0 → FETCH.
- MEM_ADDR: SrcA=1, SrcB=2, ADD, ALUOut_w=1 → LW_REQ (lw) or SW_WRITE (sw). Overflow is ignored.
- LW_REQ: M_MEM=1 → LW_WAIT.
- LW_WAIT: MEM_DATA_REG_w=1 → LW_WB.
- LW_WB: RB_w=1, M_WREG=0, M_WDATA=1 → FETCH.
- SW_WRITE: M_MEM=1, MEM_w=1 → FETCH.
- BEQ_EXEC: SrcA=1, SrcB=0, SUB, PC_w=ZERO, M_PC=1 → FETCH.
- J_EXEC: PC_w=1, M_PC=2 → FETCH.
- MULT_START: mult_control=1, counter cleared → MULT_WAIT. A mult_end seen in MULT_START is ignored.
- MULT_WAIT: counter increments each cycle.
  - mult_end=1 → MULT_DONE. mult_end wins over timeout when both occur in the same cycle.
  - counter=MULT_TIMEOUT-1 without mult_end → EXC, cause 3.
- MULT_DONE: HILO_w=1 → FETCH.
- EXC: SrcA=0, SrcB=1, SUB, EPC_w=1 (EPC = PC-4); PC_w=1, M_PC=3 → FETCH.
- exc_cause updates on entry to EXC and holds until the next exception or reset.
- No RB_w, MEM_w or HILO_w is ever asserted on an exception path.

Decomposition:
- Package control_unit_pkg holds: state enum (5-bit, RESET=0, FETCH=1, …), opcode/funct constants, ALUOp codes, all mux-select constants, exc_cause codes.
- Sub-module mult_watchdog: counter with clear/enable and a timeout flag parameterized by MULT_TIMEOUT.

Test Plan:
- Reset held low 3 cycles, then released → all outputs 0 during reset. Next cycle in FETCH: PC_w=1, M_ALUSrcB=1, ALUOp=1.
- add (op 0, funct 0x20), OVERFLOW=0 → FETCH, FETCH_WAIT, DECODE, R_EXEC, R_WB (RB_w=1, M_WREG=1), back to FETCH. 5 cycles total.
- lw (op 0x23) → 7 cycles. MEM_DATA_REG_w is asserted in cycle 6, RB_w with M_WDATA=1 in cycle 7. sw (op 0x2B) → MEM_w=1 in cycle 5 only.
- beq with ZERO=1 → PC_w=1, M_PC=1 in cycle 4. With ZERO=0 → PC_w=0 in cycle 4.
- addi with OVERFLOW=1 in ADDI_EXEC → EXC: EPC_w=1, M_PC=3; exc_cause=2; no RB_w.
- Invalid opcode → EXC, exc_cause=1.
- mult with mult_end after 10 cycles → HILO_w pulse, then FETCH.
- mult with no mult_end, MULT_TIMEOUT=8 → EXC after 8 cycles in MULT_WAIT, exc_cause=3.
- Reset asserted mid-MULT_WAIT → immediate RESET, all outputs 0.
